// File: rtl/apb_arbiter_pkg.sv
// Shared types and default widths for the two-requester APB arbiter.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_arbiter_if.sv
// Requester-side bundle: two request channels in, a shared ack/response out.
interface apb_arbiter_if
  import apb_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW
);

  logic [1:0]      i_req;
  logic [2*AW-1:0] i_addr;
  logic [1:0]      i_write;
  logic [2*DW-1:0] i_wdata;
  logic [1:0]      o_ack;
  logic [DW-1:0]   o_rdata;
  logic            o_err;

  modport master (
    output i_req, i_addr, i_write, i_wdata,
    input  o_ack, o_rdata, o_err
  );

  modport slave (
    input  i_req, i_addr, i_write, i_wdata,
    output o_ack, o_rdata, o_err
  );

endinterface

// File: rtl/apb_arbiter_rr_arb.sv
// Two-way round-robin grant; prio_q names the requester that wins a tie.
module apb_rr_arb (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       load_i,
  output logic       gnt_idx_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_idx_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx_o = prio_q;
    end else if (req_i == 2'b10) begin
      gnt_idx_o = 1'b1;
    end
    prio_d = load_i ? ~gnt_idx_o : prio_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master with round-robin arbitration.
// Optional PREADY wait limit is compiled in with APB_TIMEOUT_EN.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 255
)(
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_arbiter_if.slave  req_if,
  output logic [AW-1:0] PADDR,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [DW-1:0] PWDATA,
  input  logic          PREADY,
  input  logic [DW-1:0] PRDATA,
  input  logic          PSLVERR
);

  apb_state_e    state_q;
  logic          owner_q;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic          pwrite_q;
  logic          psel_q;
  logic          penable_q;
  logic [1:0]    ack_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          gnt_idx;
  logic          start;

`ifdef APB_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TW-1:0] tmo_q;
`endif

  // A requester still holding i_req in its ack cycle must not restart.
  assign start = (state_q == IDLE) && (|req_if.i_req) && !(|ack_q);

  apb_rr_arb u_rr_arb (
    .clk_i     (PCLK),
    .rst_n_i   (PRESETn),
    .req_i     (req_if.i_req),
    .load_i    (start),
    .gnt_idx_o (gnt_idx)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SETUP;
            owner_q  <= gnt_idx;
            psel_q   <= 1'b1;
            paddr_q  <= req_if.i_addr[gnt_idx*AW +: AW];
            pwdata_q <= req_if.i_wdata[gnt_idx*DW +: DW];
            pwrite_q <= req_if.i_write[gnt_idx];
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_q     <= TW'(TIMEOUT - 1);
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            state_q        <= IDLE;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            ack_q[owner_q] <= 1'b1;
            rdata_q        <= pwrite_q ? '0 : PRDATA;
            err_q          <= PSLVERR;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_q == '0) begin
            state_q        <= IDLE;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            ack_q[owner_q] <= 1'b1;
            rdata_q        <= '0;
            err_q          <= 1'b1;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
`endif
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign PADDR          = paddr_q;
  assign PSEL           = psel_q;
  assign PENABLE        = penable_q;
  assign PWRITE         = pwrite_q;
  assign PWDATA         = pwdata_q;
  assign req_if.o_ack   = ack_q;
  assign req_if.o_rdata = rdata_q;
  assign req_if.o_err   = err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter (TIMEOUT=4 for the timeout case).
module tb_apb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  int          n_chk = 0;
  int          n_err = 0;
  logic [1:0]  ack_seen;
  logic [31:0] addr_seen;
  int          pen_cnt;

  always #5 clk = ~clk;

  apb_arbiter_if #(.AW(32), .DW(32)) rif ();

  apb_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .req_if  (rif.slave),
    .PADDR   (paddr),
    .PSEL    (psel),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PWDATA  (pwdata),
    .PREADY  (pready),
    .PRDATA  (prdata),
    .PSLVERR (pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic [1:0] ack, output logic [31:0] addr);
    ack  = '0;
    addr = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (psel && !penable) addr = paddr;
      if (|rif.o_ack) begin
        ack = rif.o_ack;
        break;
      end
    end
  endtask

  initial begin
    rif.i_req   = 2'b00;
    rif.i_addr  = '0;
    rif.i_write = 2'b00;
    rif.i_wdata = '0;
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_ack", rif.o_ack, 0);
    chk("rst_err", rif.o_err, 0);
    chk("rst_rdata", rif.o_rdata, 0);
    rst_n = 1'b1;
    tick();

    // single write, zero wait states
    rif.i_req   = 2'b01;
    rif.i_addr  = {32'h0000_0200, 32'h0000_0010};
    rif.i_write = 2'b01;
    rif.i_wdata = {32'h0, 32'h0000_00A5};
    pready = 1'b1;
    tick();
    chk("wr_c1_psel", psel, 1);
    chk("wr_c1_penable", penable, 0);
    chk("wr_c1_paddr", paddr, 32'h10);
    chk("wr_c1_pwrite", pwrite, 1);
    chk("wr_c1_pwdata", pwdata, 32'hA5);
    tick();
    chk("wr_c2_penable", penable, 1);
    chk("wr_c2_ack", rif.o_ack, 0);
    tick();
    chk("wr_c3_ack", rif.o_ack, 2'b01);
    chk("wr_c3_err", rif.o_err, 0);
    chk("wr_c3_psel", psel, 0);
    chk("wr_c3_rdata", rif.o_rdata, 0);
    rif.i_req = 2'b00;
    tick();
    chk("wr_c4_ack", rif.o_ack, 0);

    // read from requester 1 with three wait states
    rif.i_req   = 2'b10;
    rif.i_write = 2'b00;
    pready = 1'b0;
    prdata = 32'hDEADBEEF;
    tick();
    chk("rd_setup_paddr", paddr, 32'h200);
    chk("rd_setup_pwrite", pwrite, 0);
    pen_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (penable) pen_cnt++;
      chk("rd_wait_ack", rif.o_ack, 0);
      if (i == 3) pready = 1'b1;
    end
    chk("rd_penable_cycles", pen_cnt, 4);
    tick();
    chk("rd_ack", rif.o_ack, 2'b10);
    chk("rd_rdata", rif.o_rdata, 32'hDEADBEEF);
    chk("rd_psel_drop", psel, 0);
    rif.i_req = 2'b00;
    tick(); tick();

    // contention: both held, grants alternate starting with requester 0
    rif.i_req   = 2'b11;
    rif.i_write = 2'b01;
    rif.i_addr  = {32'h0000_0200, 32'h0000_0100};
    for (int t = 0; t < 4; t++) begin
      wait_ack(ack_seen, addr_seen);
      chk("rr_grant", ack_seen, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_addr", addr_seen, (t % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_idle_psel", psel, 0);
    end
    rif.i_req = 2'b00;
    tick(); tick();

    // slave error, then a clean read
    rif.i_req = 2'b01;
    pslverr = 1'b1;
    wait_ack(ack_seen, addr_seen);
    chk("err_ack", ack_seen, 2'b01);
    chk("err_flag", rif.o_err, 1);
    rif.i_req = 2'b00;
    pslverr = 1'b0;
    tick();
    rif.i_req   = 2'b01;
    rif.i_write = 2'b00;
    prdata = 32'h1234_5678;
    wait_ack(ack_seen, addr_seen);
    chk("err_next_ack", ack_seen, 2'b01);
    chk("err_next_flag", rif.o_err, 0);
    chk("err_next_rdata", rif.o_rdata, 32'h1234_5678);
    rif.i_req = 2'b00;
    tick(); tick();

    // reset during ACCESS with PREADY low
    rif.i_req = 2'b01;
    pready = 1'b0;
    tick(); tick();
    chk("rst_mid_penable_pre", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    tick();
    chk("rst_mid_ack", rif.o_ack, 0);
    rst_n = 1'b1;
    rif.i_req = 2'b11;
    pready = 1'b1;
    wait_ack(ack_seen, addr_seen);
    chk("rst_rr_first", ack_seen, 2'b01);
    rif.i_req = 2'b00;
    tick(); tick();

`ifdef APB_TIMEOUT_EN
    // PREADY never rises: forced completion after four ACCESS cycles
    rif.i_req = 2'b01;
    pready = 1'b0;
    prdata = 32'hCAFE_F00D;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("tmo_wait_ack", rif.o_ack, 0);
      tick();
    end
    chk("tmo_last_penable", penable, 1);
    tick();
    chk("tmo_ack", rif.o_ack, 2'b01);
    chk("tmo_err", rif.o_err, 1);
    chk("tmo_rdata", rif.o_rdata, 0);
    chk("tmo_psel", psel, 0);
    rif.i_req = 2'b00;
    tick(); tick();
`else
    // without the limit ACCESS holds as long as PREADY stays low
    rif.i_req = 2'b01;
    pready = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("nto_penable", penable, 1);
    chk("nto_ack", rif.o_ack, 0);
    pready = 1'b1;
    tick();
    chk("nto_ack_late", rif.o_ack, 2'b01);
    rif.i_req = 2'b00;
    tick(); tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter TIMEOUT, default 255: PREADY wait-cycle limit, used only when APB_TIMEOUT_EN is defined.
REQ-004 PCLK  in  1  the single clock; all logic is on its rising edge.
REQ-005 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-006 i_req  in  2  per-requester transfer request, level, held until o_ack.
REQ-007 i_addr  in  2*AW  per-requester address, stable while i_req is high.
REQ-008 i_write  in  2  per-requester direction, 1 = write.
REQ-009 i_wdata  in  2*DW  per-requester write data.
REQ-010 o_ack  out  2  one-cycle completion pulse per requester.
REQ-011 o_rdata  out  DW  read data, valid with any o_ack.
REQ-012 o_err  out  1  error flag, valid with any o_ack.
REQ-013 PADDR  out  AW, PSEL  out  1, PENABLE  out  1, PWRITE  out  1, PWDATA  out  DW: APB master request signals.
REQ-014 PREADY  in  1, PRDATA  in  DW, PSLVERR  in  1: APB slave response signals.

Function
REQ-015 The FSM has three states: IDLE, SETUP (PSEL=1, PENABLE=0) and ACCESS (PSEL=1, PENABLE=1).
REQ-016 IDLE->SETUP when any i_req is high and o_ack was not asserted in the previous cycle; the winner is latched as the owner.
REQ-017 Arbitration is round-robin: on contention, the requester not served last wins; after reset, requester 0 has priority.
REQ-018 On entry to SETUP, PADDR, PWRITE and PWDATA are registered from the owner and held constant through SETUP and ACCESS.
REQ-019 SETUP->ACCESS unconditionally after exactly one cycle.
REQ-020 ACCESS holds while PREADY=0; when PREADY=1 the FSM goes to IDLE, pulses o_ack[owner] for one cycle, and registers o_rdata=PRDATA (reads only, else 0) and o_err=PSLVERR.
REQ-021 PENABLE is never high without PSEL; PSEL drops in the cycle after completion, so back-to-back transfers incur one IDLE cycle.
REQ-022 A requester dropping i_req mid-transfer does not abort the transfer; o_ack is still issued.
REQ-023 PSLVERR is sampled only in ACCESS with PREADY=1.
REQ-024 A minimum transfer takes 3 cycles, from i_req high to o_ack.

Reset
REQ-025 While PRESETn=0: state=IDLE; PSEL, PENABLE, PWRITE, o_ack, o_err = 0; PADDR, PWDATA, o_rdata = 0; round-robin pointer selects requester 0.
REQ-026 Reset asserted mid-transfer aborts immediately with no o_ack; after release, the first request starts from IDLE.

Configuration
REQ-027 With APB_TIMEOUT_EN defined, a counter runs in ACCESS; if PREADY stays low for TIMEOUT cycles, the FSM returns to IDLE with o_ack[owner]=1 and o_err=1, and o_rdata=0.
REQ-028 Without APB_TIMEOUT_EN, no counter exists and ACCESS waits indefinitely for PREADY.

Structure
REQ-029 Package apb_pkg holds the state enum (IDLE/SETUP/ACCESS) and the default AW/DW constants.
REQ-030 Sub-module apb_rr_arb (2-way round-robin grant with last-served pointer) is instantiated once.
REQ-031 The formal APB slave property checker binds to the PADDR..PSLVERR ports unchanged and passes.

Verification
REQ-032 Single write: i_req=01, addr=0x10, wdata=0xA5, PREADY=1 in ACCESS -> PSEL at cycle 1, PENABLE at cycle 2, o_ack=01 at cycle 3, o_err=0.
REQ-033 Read with wait states: i_req=10, PREADY low for 3 ACCESS cycles, PRDATA=0xDEADBEEF -> PENABLE high 4 cycles, o_ack=10, o_rdata=0xDEADBEEF.
REQ-034 Contention: i_req=11 held -> grants alternate 0,1,0,1; every transfer is separated by one IDLE cycle.
REQ-035 Error: PSLVERR=1 with PREADY=1 -> o_ack with o_err=1; the next transfer has o_err=0.
REQ-036 Reset mid-ACCESS: PRESETn low during PREADY=0 -> PSEL=PENABLE=0 asynchronously, no o_ack.
REQ-037 APB_TIMEOUT_EN, TIMEOUT=4, PREADY held 0 -> after 4 ACCESS cycles o_ack=1, o_err=1, PSEL=0 the next cycle.
